biport_link_arbiter: RTL and testbench

//  Half-duplex ownership controller for a shared bidirectional link. Two

---
 rtl/biport_link_arbiter_pkg.sv | 29 ++
 rtl/biport_link_arbiter.sv | 156 +++++++++++++++
 tb/tb_biport_link_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/biport_link_arbiter_pkg.sv
// Shared encodings for the half-duplex link arbiter: FSM states, owner ids and
// the round-robin pick used both from IDLE and at the end of a turnaround.
package biport_link_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN1 = 2'd1;
    localparam logic [1:0] ST_OWN2 = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    localparam logic OWNER_1 = 1'b0;
    localparam logic OWNER_2 = 1'b1;

    // On a tie the side that did not own the link most recently wins.
    function automatic logic [1:0] arb_pick(
        input logic req1,
        input logic req2,
        input logic last_owner
    );
        if (req1 && req2) begin
            return (last_owner == OWNER_1) ? ST_OWN2 : ST_OWN1;
        end else if (req1) begin
            return ST_OWN1;
        end else if (req2) begin
            return ST_OWN2;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/biport_link_arbiter.sv
// Round-robin ownership controller for a shared half-duplex link: grants one
// side at a time, inserts turnaround gaps and forwards words to the far side.
module biport_link_arbiter
    import biport_link_arbiter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1_i,
    input  logic             req2_i,
    input  logic             tx_valid1_i,
    input  logic             tx_valid2_i,
    input  logic [WIDTH-1:0] tx_data1_i,
    input  logic [WIDTH-1:0] tx_data2_i,
    output logic             gnt1_o,
    output logic             gnt2_o,
    output logic             rx_valid1_o,
    output logic             rx_valid2_o,
    output logic [WIDTH-1:0] rx_data1_o,
    output logic [WIDTH-1:0] rx_data2_o,
    output logic             data_en1_o,
    output logic             data_en2_o,
    output logic [WIDTH-1:0] data_out1_o,
    output logic [WIDTH-1:0] data_out2_o,
    input  logic [WIDTH-1:0] data_in1_i,
    input  logic [WIDTH-1:0] data_in2_i,
    output logic             busy_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_INIT = TW'(TURNAROUND - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d, hold_inc;
    logic [TW-1:0]    turn_q, turn_d;
    logic             accept1, accept2;

    logic             gnt1_q, gnt2_q, busy_q;
    logic [WIDTH-1:0] dout1_q, dout2_q;
    logic             new1_q, new2_q;
    logic             rxv1_q, rxv2_q;
    logic [WIDTH-1:0] rxd1_q, rxd2_q;

    assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        accept1 = 1'b0;
        accept2 = 1'b0;
        case (state_q)
            ST_IDLE: state_d = arb_pick(req1_i, req2_i, last_q);
            ST_OWN1: begin
                hold_d = hold_inc;
                if (!req1_i || (hold_q == HOLD_LAST && req2_i)) begin
                    state_d = ST_TURN;
                    turn_d  = TURN_INIT;
                end else begin
                    accept1 = tx_valid1_i;
                end
            end
            ST_OWN2: begin
                hold_d = hold_inc;
                if (!req2_i || (hold_q == HOLD_LAST && req1_i)) begin
                    state_d = ST_TURN;
                    turn_d  = TURN_INIT;
                end else begin
                    accept2 = tx_valid2_i;
                end
            end
            default: begin
                // Turnaround exits straight into the next owner, no IDLE hop.
                if (turn_q == '0) begin
                    state_d = arb_pick(req1_i, req2_i, last_q);
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
        endcase
        if (state_d == ST_OWN1 && state_q != ST_OWN1) begin
            last_d = OWNER_1;
            hold_d = '0;
        end
        if (state_d == ST_OWN2 && state_q != ST_OWN2) begin
            last_d = OWNER_2;
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= OWNER_2;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
            busy_q  <= 1'b0;
            dout1_q <= '0;
            dout2_q <= '0;
            new1_q  <= 1'b0;
            new2_q  <= 1'b0;
            rxv1_q  <= 1'b0;
            rxv2_q  <= 1'b0;
            rxd1_q  <= '0;
            rxd2_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt1_q  <= (state_d == ST_OWN1);
            gnt2_q  <= (state_d == ST_OWN2);
            busy_q  <= (state_d != ST_IDLE);
            if (accept1) begin
                dout1_q <= tx_data1_i;
            end
            if (accept2) begin
                dout2_q <= tx_data2_i;
            end
            new1_q  <= accept1;
            new2_q  <= accept2;
            // The far side sees a fresh word while its driver is enabled.
            rxv2_q  <= gnt1_q & new1_q;
            rxv1_q  <= gnt2_q & new2_q;
            if (gnt1_q && new1_q) begin
                rxd2_q <= data_in2_i;
            end
            if (gnt2_q && new2_q) begin
                rxd1_q <= data_in1_i;
            end
        end
    end

    assign gnt1_o      = gnt1_q;
    assign gnt2_o      = gnt2_q;
    assign data_en1_o  = gnt1_q;
    assign data_en2_o  = gnt2_q;
    assign data_out1_o = dout1_q;
    assign data_out2_o = dout2_q;
    assign rx_valid1_o = rxv1_q;
    assign rx_valid2_o = rxv2_q;
    assign rx_data1_o  = rxd1_q;
    assign rx_data2_o  = rxd2_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_biport_link_arbiter.sv
// Bench for biport_link_arbiter: directed grant/turnaround vectors plus a
// random phase; delivered words are checked by a queue-based monitor.
module tb_biport_link_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req1, req2, txv1, txv2;
    logic [WIDTH-1:0] txd1, txd2;
    logic             gnt1, gnt2, rxv1, rxv2, den1, den2, busy;
    logic [WIDTH-1:0] rxd1, rxd2, dout1, dout2, din1, din2;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   held1, held2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Partner wrappers: the far side samples whatever the enabled side drives.
    assign din2 = den1 ? dout1 : '0;
    assign din1 = den2 ? dout2 : '0;

    biport_link_arbiter #(.WIDTH(WIDTH), .TURNAROUND(2), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req1_i(req1), .req2_i(req2),
        .tx_valid1_i(txv1), .tx_valid2_i(txv2),
        .tx_data1_i(txd1), .tx_data2_i(txd2),
        .gnt1_o(gnt1), .gnt2_o(gnt2),
        .rx_valid1_o(rxv1), .rx_valid2_o(rxv2),
        .rx_data1_o(rxd1), .rx_data2_o(rxd2),
        .data_en1_o(den1), .data_en2_o(den2),
        .data_out1_o(dout1), .data_out2_o(dout2),
        .data_in1_i(din1), .data_in2_i(din2),
        .busy_o(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req1 = 1'b0; req2 = 1'b0;
        txv1 = 1'b0; txv2 = 1'b0;
        txd1 = '0;   txd2 = '0;
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send1(input logic [WIDTH-1:0] d);
        txv1 = 1'b1;
        txd1 = d;
        q2.push_back('{data: d, due: cyc + 2});
    endtask

    task automatic send2(input logic [WIDTH-1:0] d);
        txv2 = 1'b1;
        txd2 = d;
        q1.push_back('{data: d, due: cyc + 2});
    endtask

    // Monitor: pops the expected word whenever a side reports rx_valid.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (den1 && den2) begin
                failures++;
                $display("FAIL en_overlap cycle=%0d got=both_high exp=at_most_one", cyc);
            end
            if (rxv2) begin
                checks++;
                if (q2.size() == 0) begin
                    failures++;
                    $display("FAIL rx2_unexpected cycle=%0d got=%02h exp=none", cyc, rxd2);
                end else begin
                    mon_e = q2.pop_front();
                    if (rxd2 !== mon_e.data || cyc != mon_e.due) begin
                        failures++;
                        $display("FAIL rx2_word got=%02h@%0d exp=%02h@%0d", rxd2, cyc, mon_e.data, mon_e.due);
                    end else begin
                        $display("rx2 word=%02h cycle=%0d", rxd2, cyc);
                    end
                end
            end
            if (rxv1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rx1_unexpected cycle=%0d got=%02h exp=none", cyc, rxd1);
                end else begin
                    mon_e = q1.pop_front();
                    if (rxd1 !== mon_e.data || cyc != mon_e.due) begin
                        failures++;
                        $display("FAIL rx1_word got=%02h@%0d exp=%02h@%0d", rxd1, cyc, mon_e.data, mon_e.due);
                    end else begin
                        $display("rx1 word=%02h cycle=%0d", rxd1, cyc);
                    end
                end
            end
        end
    end

    initial begin
        // Single transfer from side 1, plus reset state.
        do_reset();
        chk("rst_gnt1", gnt1, 0);
        chk("rst_gnt2", gnt2, 0);
        chk("rst_en1", den1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_rxv2", rxv2, 0);
        req1 = 1'b1;
        tick(1);
        chk("t1_gnt1", gnt1, 1);
        chk("t1_en1", den1, 1);
        chk("t1_busy", busy, 1);
        tick(2);
        send1(8'hA5);
        tick(1);
        txv1 = 1'b0;
        chk("t1_dout1", dout1, 8'hA5);
        tick(1);
        chk("t1_rxv2", rxv2, 1);
        chk("t1_rxd2", rxd2, 8'hA5);
        req1 = 1'b0;
        tick(4);

        // Simultaneous requests, then handover with a two-cycle gap.
        do_reset();
        req1 = 1'b1; req2 = 1'b1;
        tick(1);
        chk("t2_gnt1_first", gnt1, 1);
        chk("t2_gnt2_first", gnt2, 0);
        tick(5);
        req1 = 1'b0;
        tick(1);
        chk("t2_gap_en1_c7", den1, 0);
        chk("t2_gap_en2_c7", den2, 0);
        chk("t2_gap_busy_c7", busy, 1);
        tick(1);
        chk("t2_gap_en1_c8", den1, 0);
        chk("t2_gap_en2_c8", den2, 0);
        tick(1);
        chk("t2_gnt2_c9", gnt2, 1);
        chk("t2_en2_c9", den2, 1);
        send2(8'h3C);
        tick(1);
        txv2 = 1'b0;
        tick(3);
        req2 = 1'b0;
        tick(4);

        // Both held high: 16 owned cycles each, 2-cycle gaps.
        do_reset();
        req1 = 1'b1; req2 = 1'b1;
        for (int c = 1; c <= 76; c++) begin
            int o;
            tick(1);
            o = (c - 1) % 36;
            chk("t3_gnt1", gnt1, (o < 16) ? 1 : 0);
            chk("t3_gnt2", gnt2, (o >= 18 && o < 34) ? 1 : 0);
        end
        req1 = 1'b0; req2 = 1'b0;
        tick(4);

        // Lone requester is never forced off.
        do_reset();
        req2 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            chk("t5_gnt2_hold", gnt2, 1);
        end
        req2 = 1'b0;
        tick(4);

        // Asynchronous reset in the middle of a side-2 burst.
        do_reset();
        req2 = 1'b1;
        tick(1);
        chk("t4_gnt2", gnt2, 1);
        tick(1);
        send2(8'h11);
        tick(1);
        send2(8'h22);
        tick(1);
        txv2 = 1'b0;
        #2;
        rst = 1'b1;
        q1.delete();
        q2.delete();
        #1;
        chk("t4_async_en2", den2, 0);
        chk("t4_async_gnt2", gnt2, 0);
        chk("t4_async_rxv1", rxv1, 0);
        req2 = 1'b0;
        req1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        chk("t4_after_gnt1", gnt1, 1);
        chk("t4_after_gnt2", gnt2, 0);
        req1 = 1'b0;
        tick(4);

        // Random requesters; words only sent when safely owned.
        do_reset();
        held1 = 0;
        held2 = 0;
        for (int i = 0; i < 10000; i++) begin
            held1 = gnt1 ? held1 + 1 : 0;
            held2 = gnt2 ? held2 + 1 : 0;
            txv1 = 1'b0;
            txv2 = 1'b0;
            if (req1 && gnt1 && $urandom_range(15) == 0) begin
                req1 = 1'b0;
            end else if (req1 && gnt1 && held1 != MAX_HOLD && $urandom_range(1) == 1) begin
                send1(8'($urandom));
            end else if (!req1 && $urandom_range(3) == 0) begin
                req1 = 1'b1;
            end else if (!gnt1 && $urandom_range(3) == 0) begin
                txv1 = 1'b1;
                txd1 = 8'($urandom);
            end
            if (req2 && gnt2 && $urandom_range(15) == 0) begin
                req2 = 1'b0;
            end else if (req2 && gnt2 && held2 != MAX_HOLD && $urandom_range(1) == 1) begin
                send2(8'($urandom));
            end else if (!req2 && $urandom_range(3) == 0) begin
                req2 = 1'b1;
            end else if (!gnt2 && $urandom_range(3) == 0) begin
                txv2 = 1'b1;
                txd2 = 8'($urandom);
            end
            tick(1);
        end
        txv1 = 1'b0; txv2 = 1'b0;
        req1 = 1'b0; req2 = 1'b0;
        tick(6);
        chk("t6_q1_drained", q1.size(), 0);
        chk("t6_q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
